// File: rtl/shift_step_sequencer_if.sv
// shift_step_sequencer_if: request/result handshake bundle for shift_step_sequencer
// request: in_valid/in_ready, in_data (N), in_amt (AW), in_dir (0=left, 1=right)
// result:  out_valid/out_ready, out_data (N); status: busy
interface shift_step_sequencer_if #(parameter int N = 8, parameter int AW = $clog2(N));
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [AW-1:0] in_amt;
  logic          in_dir;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          busy;
  modport master (output in_valid, in_data, in_amt, in_dir, out_ready,
                  input in_ready, out_valid, out_data, busy);
  modport slave (input in_valid, in_data, in_amt, in_dir, out_ready,
                 output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/shift_step_sequencer.sv
// shift_step_sequencer: multi-cycle logical shifter built from one shift-by-S and one shift-by-1 stage
// ports: clk, rst (sync, active-high), bus (slave side of shift_step_sequencer_if)
module shift_step_sequencer #(
  parameter int N = 8,
  parameter int S = 3
) (
  input logic clk,
  input logic rst,
  shift_step_sequencer_if.slave bus
);
  localparam int AW = $clog2(N);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] data, data_n;
  logic [AW-1:0] rem, rem_n;
  logic dir, dir_n;
  logic coarse;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data  <= '0;
      rem   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_n;
      data  <= data_n;
      rem   <= rem_n;
      dir   <= dir_n;
    end
  end
  // coarse steps are taken while they fit, so all S-steps precede the 1-steps
  always_comb begin
    coarse  = rem >= AW'(S);
    state_n = state;
    data_n  = data;
    rem_n   = rem;
    dir_n   = dir;
    if (state == IDLE && bus.in_valid) begin
      data_n  = bus.in_data;
      rem_n   = bus.in_amt;
      dir_n   = bus.in_dir;
      state_n = bus.in_amt == '0 ? DONE : SHIFT;
    end else if (state == SHIFT) begin
      data_n  = dir ? (coarse ? data >> S : data >> 1) : (coarse ? data << S : data << 1);
      rem_n   = rem - (coarse ? AW'(S) : AW'(1));
      state_n = rem_n == '0 ? DONE : SHIFT;
    end else if (state == DONE && bus.out_ready) begin
      state_n = IDLE;
    end
  end
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy      = state != IDLE;
  assign bus.out_data  = data;
endmodule

// File: tb/tb_shift_step_sequencer.sv
// tb_shift_step_sequencer: directed and randomized checks of shift_step_sequencer against an arithmetic model
module tb_shift_step_sequencer;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  shift_step_sequencer_if #(.N(8)) bus ();
  shift_step_sequencer #(.N(8), .S(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] model_shift(input logic [7:0] d, input int a, input logic r);
    return r ? d >> a : d << a;
  endfunction
  function automatic int model_lat(input int a);
    return a / 3 + a % 3 + 1;
  endfunction
  // one full operation: accept, time the result, hold under backpressure, hand off
  task automatic do_op(input string tag, input logic [7:0] d, input int a, input logic r, input int hold);
    int lat;
    logic [7:0] exp;
    exp = model_shift(d, a, r);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amt    = 3'(a);
    bus.in_dir    = r;
    bus.out_ready = hold == 0;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    bus.in_amt   = 3'($urandom);
    bus.in_dir   = 1'($urandom);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    lat = 1;
    while (!bus.out_valid && lat < 30) begin
      tick;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(model_lat(a)));
    chk({tag, "_data"}, 32'(bus.out_data), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_data"}, 32'(bus.out_data), 32'(exp));
      tick;
    end
    bus.out_ready = 1'b1;
    tick;
    chk({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_dir    = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    do_op("left7", 8'b1011_0111, 7, 1'b0, 0);
    chk("left7_value", 32'(bus.out_data), 32'h80);
    do_op("right3", 8'b1011_0111, 3, 1'b1, 0);
    chk("right3_value", 32'(bus.out_data), 32'h16);
    do_op("amt0", 8'hA5, 0, 1'b0, 0);
    chk("amt0_value", 32'(bus.out_data), 32'hA5);
    // backpressure with a request waiting in front of the busy block
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hFF;
    bus.in_amt    = 3'd5;
    bus.in_dir    = 1'b0;
    bus.out_ready = 1'b0;
    tick;
    bus.in_data = 8'h0F;
    bus.in_amt  = 3'd1;
    for (int i = 0; i < 3 && !bus.out_valid; i++) tick;
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_data", 32'(bus.out_data), 32'hE0);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick;
    end
    bus.out_ready = 1'b1;
    tick;
    chk("bp_idle_ready", 32'(bus.in_ready), 32'd1);
    tick;
    bus.in_valid = 1'b0;
    chk("bp_pending_busy", 32'(bus.busy), 32'd1);
    tick;
    chk("bp_pending_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_pending_data", 32'(bus.out_data), 32'h1E);
    tick;
    chk("bp_pending_idle", 32'(bus.in_ready), 32'd1);
    // reset during the second shift cycle abandons the operation
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hB7;
    bus.in_amt   = 3'd7;
    bus.in_dir   = 1'b0;
    tick;
    bus.in_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_data", 32'(bus.out_data), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("midrst_no_result", 32'(bus.out_valid), 32'd0);
    end
    for (int n = 0; n < 200; n++) begin
      do_op("rand", 8'($urandom), int'($urandom_range(7, 0)), 1'($urandom), int'($urandom_range(2, 0)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_step_sequencer.md
Name: shift_step_sequencer

Overview:
- Performs arbitrary logical left/right shifts of an N-bit word by sequencing one fixed shift-by-S stage and one shift-by-1 stage over multiple cycles.
- Used where a full barrel shifter is too large: one coarse and one fine stage are reused every cycle.
- Sits between a requester (valid/ready input) and a consumer (valid/ready output) and holds one operation at a time.

Parameters:
- N, 8, data width in bits (N >= 2).
- S, 3, coarse step size in bits (1 <= S < N).
- AW, $clog2(N), width of the shift-amount field, derived; never overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- in_data  input  N  operand.
- in_amt  input  AW  shift amount, 0..N-1.
- in_dir  input  1  0 = logical left, 1 = logical right.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  N  shifted result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset: state IDLE; in_ready=1, out_valid=0, busy=0, out_data=0; the internal data, remaining-count and dir registers are cleared.
- Reset has priority over every other event. Reset mid-operation abandons the operation with no output; in_ready=1 on the first cycle after reset deasserts.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. When in_valid=1, latch in_data, in_amt and in_dir.
  - in_amt==0 -> DONE.
  - Otherwise -> SHIFT with rem=in_amt.
- SHIFT: one step per cycle, in_ready=0.
  - If rem >= S: shift data by S, rem -= S.
  - Else: shift data by 1, rem -= 1.
  - Left shift fills zeros at the LSB; right shift fills zeros at the MSB; there is no arithmetic mode.
  - When a step makes rem 0 -> DONE.
- DONE: out_valid=1 and out_data = final data. out_data stays stable while out_valid=1 and out_ready=0.
  - out_ready=1 -> IDLE next cycle.
  - in_ready is 0 in DONE, so a new request cannot be accepted in the same cycle as the result handoff.
- Latency: steps = floor(amt/S) + (amt mod S). out_valid rises steps+1 cycles after the accept edge (amt=0 gives 1 cycle). Minimum request-to-request interval is steps+2 cycles.
- Coarse steps always execute before fine steps; the step count is deterministic.
- in_data, in_amt and in_dir are ignored outside the IDLE accept cycle. Changing them during SHIFT has no effect.
- in_amt values >= N cannot occur because of the AW width. For non-power-of-2 N, any value >= N is still shifted step by step and yields 0.
- out_data holds its last value after the handoff; it is meaningful only while out_valid=1.
- busy = (state != IDLE).

Test Plan:
- N=8,S=3: accept in_data=8'b1011_0111, in_amt=7, in_dir=0, out_ready=1 -> 3 SHIFT cycles (3,3,1); out_valid on cycle 4 after accept; out_data=8'b1000_0000; then IDLE.
- in_data=8'b1011_0111, in_amt=3, in_dir=1 -> one SHIFT cycle; out_data=8'b0001_0110 two cycles after accept.
- in_amt=0, in_data=8'hA5 -> out_valid the cycle after accept with out_data=8'hA5; busy high for exactly 1 cycle with out_ready=1.
- Backpressure: in_amt=5, in_dir=0, in_data=8'hFF, out_ready=0 for 6 cycles -> out_data=8'hE0 held stable with out_valid=1. in_ready stays 0 even with in_valid=1; the pending request is accepted only after out_ready=1 and the return to IDLE.
- Reset mid-op: accept in_amt=7, assert rst during the 2nd SHIFT cycle -> next cycle out_valid=0, busy=0, in_ready=1, out_data=0; no result emitted.
- Random sweep: 200 random (in_data, in_amt, in_dir) with random out_ready. Each result must equal in_data<<in_amt or in_data>>in_amt, and measured latency must equal floor(amt/3)+(amt mod 3)+1.
